// File: rtl/mcr3_mem_pkg.sv
// Shared memory-map constants and FSM state type for the MCR3 scroll ROM download path.
package mcr3_mem_pkg;

    localparam logic [24:0] MAIN_BASE = 25'h00000;
    localparam logic [24:0] SND_BASE  = 25'h0E000;
    localparam logic [24:0] SND_LAST  = 25'h11FFF;
    localparam logic [24:0] CSD_BASE  = 25'h10000;
    localparam logic [24:0] SPR_BASE  = 25'h18000;
    localparam logic [24:0] BG_BASE   = 25'h28000;
    localparam logic [24:0] END_ADDR  = 25'h47FFF;

    localparam logic [7:0]  ACK_TMO_DEF = 8'd255;
    localparam logic [15:0] RST_CNT_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } dl_state_t;

    // True when a byte at this address needs an SDRAM port (and therefore back-pressure).
    function automatic logic needs_port(input logic [24:0] a);
        return (a < BG_BASE);
    endfunction

endpackage

// File: rtl/dl_addr_decode.sv
// Combinational decode of a latched download byte address into target selects and target addresses.
module dl_addr_decode
    import mcr3_mem_pkg::*;
(
    input  logic [24:0] addr,
    output logic        sel_p1,
    output logic        sel_p2,
    output logic        sel_snd,
    output logic        sel_bg,
    output logic [22:0] p1_a,
    output logic [1:0]  p1_ds,
    output logic [18:0] p2_a,
    output logic [1:0]  p2_ds,
    output logic [13:0] snd_addr,
    output logic [16:0] bg_addr
);

    logic [23:0] swz;
    logic [19:0] spr_off;
    logic [16:0] bg_off;

    // Region selects and per-target address translation.
    always_comb begin
        sel_p1  = (addr < SPR_BASE);
        sel_snd = (addr >= SND_BASE) && (addr <= SND_LAST);
        sel_p2  = (addr >= SPR_BASE) && (addr < BG_BASE);
        sel_bg  = (addr >= BG_BASE) && (addr <= END_ADDR);

        // CSD code is stored 16-bit swizzled: bit 14 becomes the byte-lane bit.
        if (addr >= CSD_BASE) begin
            swz = {addr[23:16], addr[15], addr[13:0], addr[14]};
        end else begin
            swz = addr[23:0];
        end
        p1_a  = swz[23:1];
        p1_ds = {swz[0], ~swz[0]};

        // Offsets only need the low bits; the region checks above bound the range.
        spr_off = addr[19:0] - SPR_BASE[19:0];
        p2_a    = spr_off[19:1];
        p2_ds   = {spr_off[0], ~spr_off[0]};

        snd_addr = {~addr[13], addr[12:0]};

        bg_off  = addr[16:0] - BG_BASE[16:0];
        bg_addr = bg_off;
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Sequences index-0 HPS download bytes into SDRAM ports, sound BRAM and the background loader,
// with req/ack back-pressure, timeout/overrun flags, rom_loaded and core reset generation.
module rom_dl_sequencer
    import mcr3_mem_pkg::*;
#(
    parameter logic [15:0] RST_CNT = RST_CNT_DEF,
    parameter logic [7:0]  ACK_TMO = ACK_TMO_DEF
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        user_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        p1_req,
    output logic        p2_req,
    input  logic        p1_ack,
    input  logic        p2_ack,
    output logic [22:0] p1_a,
    output logic [18:0] p2_a,
    output logic [1:0]  p1_ds,
    output logic [1:0]  p2_ds,
    output logic [15:0] p1_d,
    output logic [15:0] p2_d,
    output logic        snd_we,
    output logic [13:0] snd_addr,
    output logic [7:0]  snd_d,
    output logic        bg_we,
    output logic [16:0] bg_addr,
    output logic [7:0]  bg_d,
    output logic        dl_busy,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        err_tmo,
    output logic        err_ovr
);

    dl_state_t   state, state_nxt;
    logic [24:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  tmo_cnt;
    logic [15:0] rst_cnt;
    logic        p1_req_q = 1'b0;
    logic        p2_req_q = 1'b0;
    logic        dl_now;
    logic        wr_ok;
    logic        ack_match;
    logic        tmo_hit;
    logic        tmo_set;
    logic        core_hold;

    logic        d_sel_p1, d_sel_p2, d_sel_snd, d_sel_bg;
    logic [22:0] d_p1_a;
    logic [1:0]  d_p1_ds;
    logic [18:0] d_p2_a;
    logic [1:0]  d_p2_ds;
    logic [13:0] d_snd_addr;
    logic [16:0] d_bg_addr;

    dl_addr_decode u_dec (
        .addr     (addr_q),
        .sel_p1   (d_sel_p1),
        .sel_p2   (d_sel_p2),
        .sel_snd  (d_sel_snd),
        .sel_bg   (d_sel_bg),
        .p1_a     (d_p1_a),
        .p1_ds    (d_p1_ds),
        .p2_a     (d_p2_a),
        .p2_ds    (d_p2_ds),
        .snd_addr (d_snd_addr),
        .bg_addr  (d_bg_addr)
    );

    assign dl_now    = ioctl_download && (ioctl_index == 8'd0);
    assign wr_ok     = ioctl_wr && dl_now;
    assign ack_match = d_sel_p1 ? (p1_ack == p1_req_q) : (p2_ack == p2_req_q);
    assign tmo_hit   = (tmo_cnt == ACK_TMO - 8'd1);
    assign p1_req    = p1_req_q;
    assign p2_req    = p2_req_q;
    assign core_hold = RESET || user_reset || !rom_loaded || dl_busy;
    assign core_reset = core_hold || (rst_cnt == 16'd1);

    // Next-state logic plus the one-cycle BRAM/bg write strobes issued in ISSUE.
    always_comb begin
        state_nxt = state;
        tmo_set   = 1'b0;
        snd_we    = 1'b0;
        snd_addr  = '0;
        snd_d     = '0;
        bg_we     = 1'b0;
        bg_addr   = '0;
        bg_d      = '0;
        case (state)
            IDLE: begin
                // Bytes past the end of the map are dropped without leaving IDLE.
                if (wr_ok && (ioctl_addr <= END_ADDR)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (d_sel_snd) begin
                    snd_we   = 1'b1;
                    snd_addr = d_snd_addr;
                    snd_d    = data_q;
                end
                if (d_sel_bg) begin
                    bg_we   = 1'b1;
                    bg_addr = d_bg_addr;
                    bg_d    = data_q;
                end
                state_nxt = (d_sel_p1 || d_sel_p2) ? WAIT : IDLE;
            end
            WAIT: begin
                if (ack_match) begin
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    tmo_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, byte latch, port output holding, wait and status flags.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            tmo_cnt    <= '0;
            ioctl_wait <= 1'b0;
            p1_a       <= '0;
            p1_ds      <= '0;
            p1_d       <= '0;
            p2_a       <= '0;
            p2_ds      <= '0;
            p2_d       <= '0;
            err_tmo    <= 1'b0;
            err_ovr    <= 1'b0;
            dl_busy    <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && wr_ok) begin
                addr_q <= ioctl_addr;
                data_q <= ioctl_dout;
            end
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 8'd1 : '0;
            ioctl_wait <= ((state == IDLE) && (state_nxt == ISSUE) && needs_port(ioctl_addr))
                          || (state_nxt == WAIT);
            if ((state == ISSUE) && d_sel_p1) begin
                p1_a  <= d_p1_a;
                p1_ds <= d_p1_ds;
                p1_d  <= {data_q, data_q};
            end
            if ((state == ISSUE) && d_sel_p2) begin
                p2_a  <= d_p2_a;
                p2_ds <= d_p2_ds;
                p2_d  <= {data_q, data_q};
            end
            err_tmo    <= err_tmo || tmo_set;
            err_ovr    <= err_ovr || (wr_ok && (state != IDLE));
            dl_busy    <= dl_now;
            rom_loaded <= rom_loaded || (dl_busy && !dl_now);
        end
    end

    // Toggle-style requests: never reset, so an ack pending across RESET is absorbed.
    always_ff @(posedge clk_sys) begin
        if (!RESET && (state == ISSUE)) begin
            if (d_sel_p1) p1_req_q <= ~p1_req_q;
            if (d_sel_p2) p2_req_q <= ~p2_req_q;
        end
    end

    // Secondary reset counter: reloads while the core is held, then counts down to zero.
    always_ff @(posedge clk_sys) begin
        if (core_hold) begin
            rst_cnt <= RST_CNT;
        end else if (rst_cnt != 16'd0) begin
            rst_cnt <= rst_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboard bench for rom_dl_sequencer: directed download bytes, SDRAM ack model, flag and reset checks.
module tb_rom_dl_sequencer;

    localparam int K_P1  = 0;
    localparam int K_P2  = 1;
    localparam int K_SND = 2;
    localparam int K_BG  = 3;

    logic        clk = 1'b0;
    logic        RESET, user_reset, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        ioctl_wait, p1_req, p2_req;
    logic        p1_ack = 1'b0;
    logic        p2_ack = 1'b0;
    logic [22:0] p1_a;
    logic [18:0] p2_a;
    logic [1:0]  p1_ds, p2_ds;
    logic [15:0] p1_d, p2_d;
    logic        snd_we, bg_we;
    logic [13:0] snd_addr;
    logic [7:0]  snd_d, bg_d;
    logic [16:0] bg_addr;
    logic        dl_busy, rom_loaded, core_reset, err_tmo, err_ovr;

    typedef struct {
        string       tag;
        int          kind;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic exp_p1_req = 1'b0;
    logic withhold = 1'b0;
    int   ack_lat = 4;

    rom_dl_sequencer dut (
        .clk_sys        (clk),
        .RESET          (RESET),
        .user_reset     (user_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .p1_req         (p1_req),
        .p2_req         (p2_req),
        .p1_ack         (p1_ack),
        .p2_ack         (p2_ack),
        .p1_a           (p1_a),
        .p2_a           (p2_a),
        .p1_ds          (p1_ds),
        .p2_ds          (p2_ds),
        .p1_d           (p1_d),
        .p2_d           (p2_d),
        .snd_we         (snd_we),
        .snd_addr       (snd_addr),
        .snd_d          (snd_d),
        .bg_we          (bg_we),
        .bg_addr        (bg_addr),
        .bg_d           (bg_d),
        .dl_busy        (dl_busy),
        .rom_loaded     (rom_loaded),
        .core_reset     (core_reset),
        .err_tmo        (err_tmo),
        .err_ovr        (err_ovr)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic expect_evt(input string tag, input int kind, input logic [22:0] a,
                              input logic [1:0] ds, input logic [15:0] d);
        exp_t e;
        e.tag = tag; e.kind = kind; e.a = a; e.ds = ds; e.d = d;
        if (kind == K_P1) exp_p1_req = ~exp_p1_req;
        sb.push_back(e);
    endtask

    task automatic mon_evt(input int kind, input logic [22:0] a, input logic [1:0] ds,
                           input logic [15:0] d);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_evt: got kind=%0d a=%0h ds=%b d=%0h, want no event", kind, a, ds, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a !== a || e.ds !== ds || e.d !== d) begin
                bad++;
                $display("FAIL %s: got kind=%0d a=%0h ds=%b d=%0h, want kind=%0d a=%0h ds=%b d=%0h",
                         e.tag, kind, a, ds, d, e.kind, e.a, e.ds, e.d);
            end
        end
    endtask

    // Monitor: every target write the DUT presents is popped and compared.
    initial begin
        logic p1_last = 1'b0;
        logic p2_last = 1'b0;
        forever begin
            @(negedge clk);
            if (snd_we) mon_evt(K_SND, {9'd0, snd_addr}, 2'b00, {8'd0, snd_d});
            if (bg_we)  mon_evt(K_BG, {6'd0, bg_addr}, 2'b00, {8'd0, bg_d});
            if (p1_req !== p1_last) begin
                mon_evt(K_P1, p1_a, p1_ds, p1_d);
                p1_last = p1_req;
            end
            if (p2_req !== p2_last) begin
                mon_evt(K_P2, {4'd0, p2_a}, p2_ds, p2_d);
                p2_last = p2_req;
            end
        end
    end

    // SDRAM model: ack follows req ack_lat cycles after the req toggle, unless withheld.
    initial begin
        int c1 = 0;
        int c2 = 0;
        forever begin
            @(posedge clk); #1;
            if (!withhold && p1_req != p1_ack) begin
                if (c1 == ack_lat) begin p1_ack = p1_req; c1 = 0; end else c1++;
            end else c1 = 0;
            if (!withhold && p2_req != p2_ack) begin
                if (c2 == ack_lat) begin p2_ack = p2_req; c2 = 0; end else c2++;
            end else c2 = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
    endtask

    // Issue one byte and count the cycles ioctl_wait stays high.
    task automatic wr_span(input string name, input logic [24:0] a, input logic [7:0] d, input int want);
        int n = 0;
        bit done = 0;
        put_byte(a, d);
        for (int i = 0; i < 400; i++) begin
            if (!ioctl_wait) begin done = 1; break; end
            n++;
            @(posedge clk); #1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s: got ioctl_wait stuck high, want release", name);
        end else chk(name, n, want);
        idle(3);
    endtask

    initial begin
        int n;
        RESET = 1'b1; user_reset = 1'b0; ioctl_download = 1'b1; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = 8'd0;
        idle(3);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_busy", dl_busy, 0);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_core", core_reset, 1);
        chk("rst_tmo", err_tmo, 0);
        chk("rst_ovr", err_ovr, 0);
        chk("rst_p1a", p1_a, 0);
        chk("rst_p1req", p1_req, 0);
        RESET = 1'b0;
        idle(1);
        chk("busy_set", dl_busy, 1);
        chk("core_in_dl", core_reset, 1);

        expect_evt("p1_basic", K_P1, 23'h1, 2'b10, 16'h5A5A);
        wr_span("p1_basic_span", 25'h00003, 8'h5A, 6);
        // Sound BRAM takes the 16 KiB window linearly from 0xE000.
        expect_evt("snd_e001", K_SND, 23'h0001, 2'b00, 16'h0011);
        expect_evt("p1_e001", K_P1, 23'h7000, 2'b10, 16'h1111);
        wr_span("snd_e001_span", 25'h0E001, 8'h11, 6);
        expect_evt("snd_10000", K_SND, 23'h2000, 2'b00, 16'h0022);
        expect_evt("p1_10000", K_P1, 23'h8000, 2'b01, 16'h2222);
        wr_span("snd_10000_span", 25'h10000, 8'h22, 6);
        expect_evt("csd_14000", K_P1, 23'h8000, 2'b10, 16'h3333);
        wr_span("csd_14000_span", 25'h14000, 8'h33, 6);
        expect_evt("csd_12000", K_P1, 23'hA000, 2'b01, 16'h3434);
        wr_span("csd_12000_span", 25'h12000, 8'h34, 6);
        expect_evt("csd_17fff", K_P1, 23'hBFFF, 2'b10, 16'h3535);
        wr_span("csd_17fff_span", 25'h17FFF, 8'h35, 6);
        expect_evt("p1_0dfff", K_P1, 23'h6FFF, 2'b10, 16'h3636);
        wr_span("p1_0dfff_span", 25'h0DFFF, 8'h36, 6);
        expect_evt("p2_18001", K_P2, 23'h0, 2'b10, 16'h4444);
        wr_span("p2_18001_span", 25'h18001, 8'h44, 6);
        expect_evt("p2_27ffe", K_P2, 23'h7FFF, 2'b01, 16'h4545);
        wr_span("p2_27ffe_span", 25'h27FFE, 8'h45, 6);
        expect_evt("bg_28010", K_BG, 23'h10, 2'b00, 16'h0055);
        wr_span("bg_28010_span", 25'h28010, 8'h55, 0);
        expect_evt("bg_47fff", K_BG, 23'h1FFFF, 2'b00, 16'h0056);
        wr_span("bg_47fff_span", 25'h47FFF, 8'h56, 0);
        wr_span("drop_48000_span", 25'h48000, 8'h66, 0);
        chk("no_err_yet", {err_tmo, err_ovr}, 0);

        withhold = 1'b1;
        expect_evt("p1_tmo", K_P1, 23'h8, 2'b01, 16'h7777);
        wr_span("tmo_span", 25'h00010, 8'h77, 256);
        chk("tmo_flag", err_tmo, 1);
        withhold = 1'b0;
        idle(8);

        expect_evt("p1_ovr", K_P1, 23'h10, 2'b01, 16'h8888);
        put_byte(25'h00020, 8'h88);
        idle(2);
        put_byte(25'h00040, 8'h99);
        for (int i = 0; i < 50 && ioctl_wait; i++) idle(1);
        chk("ovr_wait_drop", ioctl_wait, 0);
        chk("ovr_flag", err_ovr, 1);
        idle(3);

        withhold = 1'b1;
        expect_evt("p1_rst", K_P1, 23'h18, 2'b01, 16'hABAB);
        put_byte(25'h00030, 8'hAB);
        idle(2);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        chk("rstwait_wait", ioctl_wait, 0);
        chk("rstwait_req", p1_req, exp_p1_req);
        chk("rstwait_tmo", err_tmo, 0);
        chk("rstwait_ovr", err_ovr, 0);
        chk("rstwait_loaded", rom_loaded, 0);
        idle(1);
        chk("rstwait_idle", ioctl_wait, 0);
        withhold = 1'b0;
        idle(8);
        expect_evt("p1_after_rst", K_P1, 23'h1, 2'b01, 16'hCDCD);
        wr_span("after_rst_span", 25'h00002, 8'hCD, 6);

        ioctl_download = 1'b0;
        idle(1);
        chk("end_busy", dl_busy, 0);
        chk("end_loaded", rom_loaded, 1);
        chk("end_core", core_reset, 0);
        n = 0;
        for (int i = 0; i < 70000; i++) begin
            idle(1);
            n++;
            if (core_reset) break;
        end
        chk("rst_pulse_gap", n, 65534);
        idle(1);
        chk("rst_pulse_width", core_reset, 0);

        ioctl_download = 1'b1;
        ioctl_index = 8'd1;
        wr_span("idx1_span", 25'h00004, 8'h12, 0);
        chk("idx1_busy", dl_busy, 0);
        chk("idx1_core", core_reset, 0);
        idle(5);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
